// File: rtl/rf_seq_pkg.sv
// Shared opcode, shift and state definitions for the register-file sequencer.
// Imported by the sequencer top level and its ALU.
package rf_seq_pkg;

   localparam int DATA_W = 16;
   localparam int REG_W  = 3;

   localparam logic [2:0] OP_MOVI = 3'b000;
   localparam logic [2:0] OP_MOV  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_CMP  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_MVN  = 3'b101;

   localparam logic [1:0] SH_NONE = 2'b00;
   localparam logic [1:0] SH_LSL  = 2'b01;
   localparam logic [1:0] SH_LSR  = 2'b10;
   localparam logic [1:0] SH_ASR  = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      RD_N,
      RD_M,
      EXEC,
      WB,
      DONE
   } rf_seq_state_t;

   function automatic logic op_illegal(input logic [2:0] op);
      return (op > OP_MVN);
   endfunction

   function automatic logic op_sets_flags(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_CMP) || (op == OP_AND) || (op == OP_MVN);
   endfunction

endpackage

// File: rtl/rf_seq_alu.sv
// Combinational shifter and ALU for the register-file sequencer.
// The shift always applies to the B (Rm) operand only.
module rf_seq_alu
   import rf_seq_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [2:0]        op,
   input  logic [1:0]        sh,
   output logic [DATA_W-1:0] result,
   output logic              n,
   output logic              v,
   output logic              z
);

   logic [DATA_W-1:0] b_sh;

   always_comb begin
      unique case (sh)
         SH_LSL:  b_sh = {b[DATA_W-2:0], 1'b0};
         SH_LSR:  b_sh = {1'b0, b[DATA_W-1:1]};
         SH_ASR:  b_sh = {b[DATA_W-1], b[DATA_W-1:1]};
         default: b_sh = b;
      endcase
   end

   // NOTE: every output gets a default first so no path through the case infers a latch.
   always_comb begin
      result = b_sh;
      v      = 1'b0;
      case (op)
         OP_ADD: begin
            result = a + b_sh;
            v      = (a[DATA_W-1] == b_sh[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
         end
         OP_CMP: begin
            result = a - b_sh;
            v      = (a[DATA_W-1] != b_sh[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
         end
         OP_AND:  result = a & b_sh;
         OP_MVN:  result = ~b_sh;
         default: result = b_sh;
      endcase
      n = result[DATA_W-1];
      z = (result == '0);
   end

endmodule

// File: rtl/regfile_sequencer.sv
// Initiator-side controller for the 8x16 register file: fetches operands,
// runs the ALU/shift, writes back and maintains the N/V/Z flags.
module regfile_sequencer
   import rf_seq_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   output logic              ready,
   input  logic [2:0]        cmd_op,
   input  logic [REG_W-1:0]  cmd_rd,
   input  logic [REG_W-1:0]  cmd_rn,
   input  logic [REG_W-1:0]  cmd_rm,
   input  logic [1:0]        cmd_sh,
   input  logic [7:0]        cmd_imm,
   output logic              done,
   output logic              err,
   output logic [REG_W-1:0]  rf_readnum,
   input  logic [DATA_W-1:0] rf_data_out,
   output logic [REG_W-1:0]  rf_writenum,
   output logic              rf_write,
   output logic [DATA_W-1:0] rf_data_in,
   output logic [2:0]        flags
);

   rf_seq_state_t state, state_nx;

   logic [2:0]        op_q;
   logic [REG_W-1:0]  rd_q, rn_q, rm_q;
   logic [1:0]        sh_q;
   logic [7:0]        imm_q;
   logic [DATA_W-1:0] a_q, b_q, c_q;
   logic [DATA_W-1:0] alu_result;
   logic              alu_n, alu_v, alu_z;
   logic              accept;

   assign accept = start && (state == IDLE);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (start) begin
            if (op_illegal(cmd_op))                           state_nx = DONE;
            else if (cmd_op == OP_MOVI)                       state_nx = EXEC;
            else if ((cmd_op == OP_MOV) || (cmd_op == OP_MVN)) state_nx = RD_M;
            else                                              state_nx = RD_N;
         end
         RD_N:    state_nx = RD_M;
         RD_M:    state_nx = EXEC;
         EXEC:    state_nx = (op_q == OP_CMP) ? DONE : WB;
         WB:      state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      ready       = (state == IDLE);
      done        = (state == DONE);
      err         = (state == DONE) && op_illegal(op_q);
      rf_write    = (state == WB);
      rf_writenum = (state == WB) ? rd_q : '0;
      rf_data_in  = c_q;
      unique case (state)
         RD_N:    rf_readnum = rn_q;
         RD_M:    rf_readnum = rm_q;
         default: rf_readnum = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_q  <= '0;
         rd_q  <= '0;
         rn_q  <= '0;
         rm_q  <= '0;
         sh_q  <= '0;
         imm_q <= '0;
      end else if (accept) begin
         op_q  <= cmd_op;
         rd_q  <= cmd_rd;
         rn_q  <= cmd_rn;
         rm_q  <= cmd_rm;
         sh_q  <= cmd_sh;
         imm_q <= cmd_imm;
      end
   end

   rf_seq_alu u_alu (
      .a      (a_q),
      .b      (b_q),
      .op     (op_q),
      .sh     (sh_q),
      .result (alu_result),
      .n      (alu_n),
      .v      (alu_v),
      .z      (alu_z)
   );

   // Sources are captured before WB, so Rd may alias Rn or Rm safely.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_q   <= '0;
         b_q   <= '0;
         c_q   <= '0;
         flags <= '0;
      end else begin
         if (state == RD_N) a_q <= rf_data_out;
         if (state == RD_M) b_q <= rf_data_out;
         if (state == EXEC) begin
            c_q <= (op_q == OP_MOVI) ? {{8{imm_q[7]}}, imm_q} : alu_result;
            if (op_sets_flags(op_q)) flags <= {alu_n, alu_v, alu_z};
         end
      end
   end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed self-checking bench for regfile_sequencer with a behavioural
// 8x16 register file attached to the rf_* ports.
module tb_regfile_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic        ready;
   logic [2:0]  cmd_op;
   logic [2:0]  cmd_rd, cmd_rn, cmd_rm;
   logic [1:0]  cmd_sh;
   logic [7:0]  cmd_imm;
   logic        done, err;
   logic [2:0]  rf_readnum, rf_writenum;
   logic [15:0] rf_data_out, rf_data_in;
   logic        rf_write;
   logic [2:0]  flags;

   logic [15:0] regs [8];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   regfile_sequencer dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .ready       (ready),
      .cmd_op      (cmd_op),
      .cmd_rd      (cmd_rd),
      .cmd_rn      (cmd_rn),
      .cmd_rm      (cmd_rm),
      .cmd_sh      (cmd_sh),
      .cmd_imm     (cmd_imm),
      .done        (done),
      .err         (err),
      .rf_readnum  (rf_readnum),
      .rf_data_out (rf_data_out),
      .rf_writenum (rf_writenum),
      .rf_write    (rf_write),
      .rf_data_in  (rf_data_in),
      .flags       (flags)
   );

   // Register file: combinational read, write on the rising edge, no reset.
   assign rf_data_out = regs[rf_readnum];
   always @(posedge clk) if (rf_write) regs[rf_writenum] <= rf_data_in;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic set_cmd(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rn,
                          input logic [2:0] rm, input logic [1:0] sh, input logic [7:0] imm);
      cmd_op  = op;
      cmd_rd  = rd;
      cmd_rn  = rn;
      cmd_rm  = rm;
      cmd_sh  = sh;
      cmd_imm = imm;
   endtask

   // Issue one command; returns cycles to done plus err and any-write observations.
   task automatic do_cmd(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rn,
                         input logic [2:0] rm, input logic [1:0] sh, input logic [7:0] imm,
                         output int lat, output logic err_seen, output logic wr_seen);
      int n;
      @(negedge clk);
      n = 0;
      while (!ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      set_cmd(op, rd, rn, rm, sh, imm);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start   = 1'b0;
      n       = 1;
      wr_seen = rf_write;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
         wr_seen |= rf_write;
      end
      lat      = n;
      err_seen = err;
   endtask

   initial begin
      int   lat, n;
      logic e, w;
      logic [2:0] flags_at_done;

      reset_n = 1'b0;
      start   = 1'b0;
      set_cmd(3'd0, 3'd0, 3'd0, 3'd0, 2'd0, 8'd0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_write", 32'(rf_write), 32'd0);
      check("rst_readnum", 32'(rf_readnum), 32'd0);
      check("rst_writenum", 32'(rf_writenum), 32'd0);
      check("rst_data_in", 32'(rf_data_in), 32'd0);
      check("rst_flags", 32'(flags), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // MOVI R3,#0x85
      do_cmd(3'b000, 3'd3, 3'd0, 3'd0, 2'b00, 8'h85, lat, e, w);
      check("movi_lat", 32'(lat), 32'd3);
      check("movi_r3", 32'(regs[3]), 32'hFF85);
      check("movi_flags", 32'(flags), 32'd0);
      check("movi_err", 32'(e), 32'd0);

      // MOVI R0,#0x7F ; MOV R1,R0,LSL ; ADD R2,R1,R1
      do_cmd(3'b000, 3'd0, 3'd0, 3'd0, 2'b00, 8'h7F, lat, e, w);
      check("movi_r0", 32'(regs[0]), 32'h007F);
      do_cmd(3'b001, 3'd1, 3'd0, 3'd0, 2'b01, 8'h00, lat, e, w);
      check("mov_lat", 32'(lat), 32'd4);
      check("mov_lsl_r1", 32'(regs[1]), 32'h00FE);
      do_cmd(3'b010, 3'd2, 3'd1, 3'd1, 2'b00, 8'h00, lat, e, w);
      check("add_lat", 32'(lat), 32'd5);
      check("add_r2", 32'(regs[2]), 32'h01FC);
      check("add_flags", 32'(flags), 32'b000);

      // R4=0x7FFF via MOVI #0xFF then LSR; R5=1; ADD R6,R4,R5 overflows
      do_cmd(3'b000, 3'd4, 3'd0, 3'd0, 2'b00, 8'hFF, lat, e, w);
      do_cmd(3'b001, 3'd4, 3'd0, 3'd4, 2'b10, 8'h00, lat, e, w);
      check("mov_lsr_r4", 32'(regs[4]), 32'h7FFF);
      do_cmd(3'b000, 3'd5, 3'd0, 3'd0, 2'b00, 8'h01, lat, e, w);
      do_cmd(3'b010, 3'd6, 3'd4, 3'd5, 2'b00, 8'h00, lat, e, w);
      check("addv_lat", 32'(lat), 32'd5);
      check("addv_r6", 32'(regs[6]), 32'h8000);
      check("addv_flags", 32'(flags), 32'b110);

      // CMP R2,R2
      do_cmd(3'b011, 3'd0, 3'd2, 3'd2, 2'b00, 8'h00, lat, e, w);
      check("cmp_lat", 32'(lat), 32'd4);
      check("cmp_flags", 32'(flags), 32'b001);
      check("cmp_no_write", 32'(w), 32'd0);
      check("cmp_r2", 32'(regs[2]), 32'h01FC);

      // Illegal opcode
      do_cmd(3'b110, 3'd2, 3'd0, 3'd0, 2'b00, 8'h00, lat, e, w);
      check("ill_lat", 32'(lat), 32'd1);
      check("ill_err", 32'(e), 32'd1);
      check("ill_no_write", 32'(w), 32'd0);
      check("ill_flags", 32'(flags), 32'b001);

      // R7 = R6 = 0x8000
      do_cmd(3'b001, 3'd7, 3'd0, 3'd6, 2'b00, 8'h00, lat, e, w);
      check("mov_r7", 32'(regs[7]), 32'h8000);

      // Busy: ADD R3,R6,R5 with start held; MVN R7,R7,ASR queued on the bus
      @(negedge clk);
      set_cmd(3'b010, 3'd3, 3'd6, 3'd5, 2'b00, 8'h00);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      set_cmd(3'b101, 3'd7, 3'd0, 3'd7, 2'b11, 8'h00);
      n = 1;
      flags_at_done = 3'b111;
      while (!ready && n < 20) begin
         if (done) flags_at_done = flags;
         @(negedge clk);
         n++;
      end
      check("busy_ready_cycle", 32'(n), 32'd6);
      check("busy_add_r3", 32'(regs[3]), 32'h8001);
      check("busy_add_flags", 32'(flags_at_done), 32'b100);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      n = 1;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("mvn_lat", 32'(n), 32'd4);
      check("mvn_asr_r7", 32'(regs[7]), 32'h3FFF);
      check("mvn_flags", 32'(flags), 32'b000);

      // Set Z so the reset clearing flags is visible
      do_cmd(3'b011, 3'd0, 3'd2, 3'd2, 2'b00, 8'h00, lat, e, w);
      check("cmp2_flags", 32'(flags), 32'b001);

      // Reset during WB of MOVI R1,#1
      @(negedge clk);
      set_cmd(3'b000, 3'd1, 3'd0, 3'd0, 2'b00, 8'h01);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("rstwb_in_wb", 32'(rf_write), 32'd1);
      reset_n = 1'b0;
      #1;
      check("rstwb_write_drop", 32'(rf_write), 32'd0);
      check("rstwb_ready", 32'(ready), 32'd1);
      check("rstwb_flags", 32'(flags), 32'b000);
      @(posedge clk);
      #1;
      check("rstwb_r1_kept", 32'(regs[1]), 32'h00FE);
      @(negedge clk);
      reset_n = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_sequencer.md
# regfile_sequencer

Initiator-side controller for the 8×16-bit register file. It accepts one register-transfer command at a time over a start/ready handshake and drives the register file's read port (`readnum`/`data_out`) and write port (`writenum`/`write`/`data_in`). It performs the operand fetch, ALU/shift, and write-back sequence, and updates N/V/Z status flags. It sits between the instruction decoder and the register file, and is the only block that drives the register file's control inputs.

## Interface
Parameters: none. Width is fixed at 16 bits and the register count at 8.

- `clk` in 1: rising-edge clock, shared with the register file.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: command valid. Accepted only when `ready`=1.
- `ready` out 1: high only in IDLE.
- `cmd_op` in 3: opcode.
- `cmd_rd`, `cmd_rn`, `cmd_rm` in 3 each: destination and source register numbers.
- `cmd_sh` in 2: shift applied to the Rm operand.
- `cmd_imm` in 8: immediate for MOVI.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: valid only with `done`; 1 means the opcode was illegal.
- `rf_readnum` out 3: to the register file's `readnum`.
- `rf_data_out` in 16: from the register file. The register file drives it combinationally from `readnum`.
- `rf_writenum` out 3, `rf_write` out 1, `rf_data_in` out 16: to the register file's write port.
- `flags` out 3: {N, V, Z}.

## Operation
- **Command latch.** On a rising edge with `start`&`ready`, all `cmd_*` fields are latched. `start` while busy is ignored and is not queued.
- **Opcodes:**
  - 000 MOVI: Rd=sext(imm8).
  - 001 MOV: Rd=sh(Rm).
  - 010 ADD: Rd=Rn+sh(Rm).
  - 011 CMP: flags only, from Rn−sh(Rm).
  - 100 AND: Rd=Rn&sh(Rm).
  - 101 MVN: Rd=~sh(Rm).
  - 110 and 111: illegal.
- **Shift (`cmd_sh`):**
  - 00: none.
  - 01: LSL 1, zero fill.
  - 10: LSR 1, zero fill.
  - 11: ASR 1, MSB replicated.
- **States:** IDLE, RD_N, RD_M, EXEC, WB, DONE.
- **Paths from IDLE:**
  - ADD, AND: RD_N→RD_M→EXEC→WB→DONE.
  - CMP: RD_N→RD_M→EXEC→DONE.
  - MOV, MVN: RD_M→EXEC→WB→DONE.
  - MOVI: EXEC→WB→DONE.
  - Illegal: DONE with `err`=1. No register write and no flag change.
- **Operand capture.**
  - RD_N: `rf_readnum`=Rn; `rf_data_out` is captured into A at the end of the cycle.
  - RD_M: `rf_readnum`=Rm; the value is captured into B.
  - All other states: `rf_readnum`=0.
- **EXEC.** Computes the result into C, all arithmetic modulo 2^16. Flags update only on ADD, CMP, AND, MVN:
  - N = result[15].
  - Z = (result==0).
  - V = signed overflow for ADD and CMP; V=0 for AND and MVN.
- **WB.** `rf_write`=1, `rf_writenum`=Rd, `rf_data_in`=C. In every other state, `rf_write`=0 and `rf_writenum`=0. `rf_data_in` always shows C.
- **DONE.** `done`=1 for exactly one cycle, then IDLE.
- **Register aliasing.** Rd equal to Rn or Rm is legal; the sources are read before the write.

## Timing
- **Reset values:**
  - state IDLE, `ready`=1.
  - `done`=0, `err`=0.
  - `rf_write`=0, `rf_readnum`=0, `rf_writenum`=0.
  - `rf_data_in`=0 (C=0).
  - `flags`=000.
- **Latency.** Counted in cycles from the accepting edge to the cycle where `done` is high:
  - ADD, AND: 5.
  - MOV, MVN, CMP: 4.
  - MOVI: 3.
  - Illegal: 1.
- **Write timing.** The register file updates on the edge that ends WB. By the DONE cycle, a read of Rd returns the new value.
- **Back-to-back commands.** `ready` rises the cycle after DONE. The earliest next accept is the edge ending that IDLE cycle.
- **Reset mid-operation.** Returns to IDLE immediately and drops `rf_write` asynchronously. No partial write completes. Register file contents are untouched, since the register file has no reset.
- **Outputs.** Control outputs (`rf_*`, `ready`, `done`) are decoded from the state register and latched command fields only. There are no combinational paths from `cmd_*` or `start` to outputs.

## Structure
- **Package `rf_seq_pkg`:**
  - opcode constants `OP_MOVI` … `OP_MVN`.
  - shift constants `SH_NONE`, `SH_LSL`, `SH_LSR`, `SH_ASR`.
  - state enum `rf_seq_state_t`.
- **Sub-module `rf_seq_alu`:** purely combinational shifter and ALU.
  - Inputs: A, B, op, sh.
  - Outputs: result, N, V, Z.
- **Top level:** holds the FSM, the latched command, and the A/B/C and flag registers.

## Test plan
The bench instantiates the existing `regfile` wired to the `rf_*` ports.

- **MOVI basics.** MOVI R3,#0x85 → R3=0xFF85, `done` on cycle 3, flags=000 (unchanged).
- **ADD with overflow.** MOVI R0,#0x7F; MOV R1,R0,LSL (R1=0x00FE); ADD R2,R1,R1 → R2=0x01FC, N=0, V=0, Z=0. Then a 16-bit overflow case: R4=0x7FFF, R5=1, ADD R6,R4,R5 → R6=0x8000, N=1, V=1, `done` on cycle 5.
- **CMP equal operands.** CMP R2,R2 → Z=1, N=0, V=0. No `rf_write` pulse during the command; R2 unchanged.
- **Illegal opcode.** `cmd_op`=110 → `done`&`err` in cycle 1. `rf_write` never asserted; flags unchanged.
- **Busy and aliasing.** `start` held high during an ADD → the second command is accepted only after DONE plus one IDLE cycle. MVN R7,R7,ASR with R7=0x8000 → R7=0x3FFF, N=0.
- **Reset during WB.** Assert `reset_n`=0 in the WB cycle of MOVI R1,#1, asynchronously before the edge → R1 retains its old value, `ready`=1, `flags`=000.
